// File: rtl/if_id_hazard_controller.sv
// if_id_hazard_controller: IF/ID hold, PC enable, flush and bubble sequencing for load-use, redirect and lwn/swn.
module if_id_hazard_controller #(
    parameter int NEXTRA = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       if_id_opcode,
    input  logic [5:0]       if_id_funct,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             redirect,
    output logic             Stall_Or_Not,
    output logic             pc_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [2:0]       micro_phase,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, LU_STALL, MULTI, FLUSH} state_t;
    state_t state, state_n;
    logic [2:0] micro_n;
    logic multi_done, multi_done_n, multi_op, load_use, multi_end;
    assign multi_op = if_id_opcode == 6'b000001 && (if_id_funct == 6'b100001 || if_id_funct == 6'b010011);
    assign load_use = id_ex_mem_read && id_ex_rt != 5'd0 &&
                      (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
    assign multi_end = state == MULTI && micro_phase == 3'(NEXTRA);
    // Outputs decode straight from registered state, so they only change on posedge.
    assign Stall_Or_Not = state == LU_STALL || state == MULTI;
    assign pc_write     = !Stall_Or_Not;
    assign if_id_flush  = state == FLUSH;
    assign id_ex_bubble = state == LU_STALL || state == FLUSH;
    always_comb begin
        state_n      = RUN;
        micro_n      = 3'd0;
        multi_done_n = state == RUN ? 1'b0 : multi_done;
        if (redirect) begin
            state_n      = FLUSH;
            multi_done_n = 1'b0;
        end else if (state == RUN && load_use) begin
            state_n = LU_STALL;
        end else if (state == RUN && multi_op && !multi_done) begin
            state_n = MULTI;
            micro_n = 3'd1;
        end else if (state == MULTI) begin
            state_n      = multi_end ? RUN : MULTI;
            micro_n      = multi_end ? 3'd0 : micro_phase + 3'd1;
            multi_done_n = multi_end;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            micro_phase  <= 3'd0;
            multi_done   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_n;
            micro_phase  <= micro_n;
            multi_done   <= multi_done_n;
            stall_cycles <= (Stall_Or_Not && stall_cycles != '1) ? stall_cycles + 1'b1 : stall_cycles;
        end
    end
endmodule

// File: doc/if_id_hazard_controller.md
Name: if_id_hazard_controller

Overview:
- Sequences the IF/ID pipeline register. Generates the IF/ID hold (Stall_Or_Not), the PC write enable, the IF/ID flush and the ID/EX bubble.
- Handles three hazard classes: load-use hazards, control redirects (taken branch or jump), and the multi-cycle lwn/swn instructions.
- Keeps a saturating stall-cycle counter for performance debug.
- Sits between decode (IF/ID outputs), the ID/EX register and the branch resolution logic.

Parameters:
- NEXTRA, 1: extra ID cycles an lwn/swn instruction occupies. Range 1..7.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock. The controller updates on posedge; IF/ID samples on negedge.
- reset  in  1  asynchronous, active-high reset.
- if_id_opcode  in  6  opcode of the instruction in ID.
- if_id_funct  in  6  funct field of the instruction in ID.
- if_id_rs  in  5  rs of the instruction in ID.
- if_id_rt  in  5  rt of the instruction in ID.
- if_id_uses_rt  in  1  1 if the ID instruction reads rt as a source.
- id_ex_mem_read  in  1  the instruction in EX is a load.
- id_ex_rt  in  5  destination register of the instruction in EX.
- redirect  in  1  taken branch or jump, resolved this cycle.
- Stall_Or_Not  out  1  1 = IF/ID holds its contents.
- pc_write  out  1  1 = PC may update.
- if_id_flush  out  1  1 = IF/ID loads a NOP.
- id_ex_bubble  out  1  1 = ID/EX loads control zeros.
- micro_phase  out  3  lwn/swn sub-step index presented to decode.
- stall_cycles  out  CNT_W  saturating count of cycles with Stall_Or_Not=1.

Behaviour:
- All outputs are registered on posedge clk, so they are stable before the IF/ID negedge.
- Reset (async, active-high) drives:
  - state=RUN, Stall_Or_Not=0, pc_write=1, if_id_flush=0, id_ex_bubble=0, micro_phase=0, stall_cycles=0.
  - multi_done=0.
- Reset asserted mid-stall aborts the stall immediately.
- Decode terms:
  - lwn: opcode=000001 and funct=100001.
  - swn: opcode=000001 and funct=010011.
  - load_use: id_ex_mem_read, and id_ex_rt!=0, and (id_ex_rt==if_id_rs, or if_id_uses_rt with id_ex_rt==if_id_rt).
- States: RUN, LU_STALL, MULTI, FLUSH.
- Evaluation order at each posedge, highest priority first:
  1. redirect → FLUSH from any state. Outputs for one cycle: if_id_flush=1, id_ex_bubble=1, Stall_Or_Not=0, pc_write=1, micro_phase=0. multi_done clears; any MULTI or LU_STALL in progress is abandoned.
  2. load_use in RUN → LU_STALL for exactly one cycle. Outputs: Stall_Or_Not=1, pc_write=0, id_ex_bubble=1. The next state is RUN unconditionally; a second consecutive load_use re-enters LU_STALL.
  3. (lwn or swn), multi_done=0, in RUN → MULTI. Outputs: Stall_Or_Not=1, pc_write=0, id_ex_bubble=0, micro_phase=1.
     - Each following cycle micro_phase increments.
     - After NEXTRA cycles in MULTI: go to RUN, set multi_done=1, release the stall, micro_phase=0.
     - multi_done clears on the first cycle IF/ID advances (Stall_Or_Not=0 and not FLUSH → new instruction). This prevents re-triggering on the same lwn/swn.
  4. Otherwise RUN: Stall_Or_Not=0, pc_write=1, if_id_flush=0, id_ex_bubble=0.
- FLUSH always returns to RUN after one cycle.
- load_use while in MULTI is ignored. The extra cycles already separate the load from its use.
- Invariant: Stall_Or_Not and if_id_flush are never both 1.
- stall_cycles increments in every cycle where the registered Stall_Or_Not=1. It saturates at 2^CNT_W−1 and never wraps.

Test Plan:
- Reset: assert reset asynchronously between edges → all outputs take their reset values immediately. After release, pc_write=1, Stall_Or_Not=0.
- Load-use: id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 for one cycle → exactly one cycle of Stall_Or_Not=1, pc_write=0, id_ex_bubble=1, then RUN, stall_cycles=1. Repeat with id_ex_rt=0 → no stall.
- lwn with NEXTRA=2: opcode=000001, funct=100001 held → Stall_Or_Not=1 for 2 cycles with micro_phase 1 then 2, then 0 and released. No re-stall while the same instruction is still in ID.
- Redirect during MULTI: assert redirect on MULTI cycle 1 → next cycle if_id_flush=1, id_ex_bubble=1, Stall_Or_Not=0, micro_phase=0; then RUN.
- Simultaneous redirect and load_use → FLUSH wins; no LU_STALL cycle follows.
- Saturation with CNT_W=4: force 20 load-use stalls → stall_cycles stops at 15.
